// File: rtl/time_set_ctrl.sv
// HH:MM:SS BCD timekeeper with RUN/SET mode FSM, field blink control and idle timeout.
// Optional build macro INC_REPEAT_EN adds auto-repeat increment while btn_inc_lvl is held.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_S  = 30,
    parameter int unsigned REPEAT_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_inc_lvl,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       blink_en,
    output logic [1:0] blink_sel,
    output logic       setting
);

    // Encoding doubles as the blink_sel field code.
    typedef enum logic [1:0] {
        ST_SET_HH = 2'b00,
        ST_SET_MM = 2'b01,
        ST_SET_SS = 2'b10,
        ST_RUN    = 2'b11
    } state_t;

    localparam int unsigned IW = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_S > 0) ? TIMEOUT_S - 1 : 0);

    state_t        state_q, state_d;
    logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic          blink_q, blink_d;
    logic [IW-1:0] idle_q, idle_d;

    logic in_set, any_btn, activity, timeout_hit, state_chg;
    logic inc_req, edit_ok, edit_inc, edit_dec, rep_fire;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'h9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)
            return max;
        else if (v[3:0] == 4'h0)
            return {v[7:4] - 4'd1, 4'h9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign in_set    = (state_q != ST_RUN);
    assign any_btn   = btn_mode | btn_inc | btn_dec;
    assign activity  = any_btn | rep_fire;
    assign state_chg = (state_d != state_q);

`ifdef INC_REPEAT_EN
    localparam int unsigned RW = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_DLY);

    logic [RW-1:0] rep_q, rep_d;

    // Once the hold count saturates, every further 2 Hz tick is one increment.
    assign rep_fire = in_set & btn_inc_lvl & tick_2hz & ~btn_mode & (rep_q == REP_MAX);

    always_comb begin
        rep_d = rep_q;
        if (!in_set || !btn_inc_lvl || state_chg)
            rep_d = '0;
        else if (tick_2hz && (rep_q != REP_MAX))
            rep_d = rep_q + RW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rep_q <= '0;
        else
            rep_q <= rep_d;
    end
`else
    logic unused_inc_lvl;
    assign unused_inc_lvl = btn_inc_lvl;
    assign rep_fire       = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_S != 0) && in_set && tick_1hz && !activity &&
                         (idle_q == IDLE_LAST);

    // An edit applies only when exactly one direction is requested and mode is idle.
    assign inc_req  = btn_inc | rep_fire;
    assign edit_ok  = in_set && !btn_mode && (inc_req ^ btn_dec);
    assign edit_inc = edit_ok & inc_req;
    assign edit_dec = edit_ok & btn_dec;

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            hh_q    <= 8'h00;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            blink_q <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            blink_q <= blink_d;
            idle_q  <= idle_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (btn_mode) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HH;
                ST_SET_HH: state_d = ST_SET_MM;
                ST_SET_MM: state_d = ST_SET_SS;
                default:   state_d = ST_RUN;
            endcase
        end else if (timeout_hit) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        hh_d = hh_q;
        mm_d = mm_q;
        ss_d = ss_q;
        if ((state_q == ST_RUN) && tick_1hz && !btn_mode) begin
            ss_d = bcd_inc(ss_q, 8'h59);
            if (ss_q == 8'h59) begin
                mm_d = bcd_inc(mm_q, 8'h59);
                if (mm_q == 8'h59)
                    hh_d = bcd_inc(hh_q, 8'h23);
            end
        end else if (edit_ok) begin
            case (state_q)
                ST_SET_HH: hh_d = edit_inc ? bcd_inc(hh_q, 8'h23) : bcd_dec(hh_q, 8'h23);
                ST_SET_MM: mm_d = edit_inc ? bcd_inc(mm_q, 8'h59) : bcd_dec(mm_q, 8'h59);
                ST_SET_SS: ss_d = edit_inc ? bcd_inc(ss_q, 8'h59) : bcd_dec(ss_q, 8'h59);
                default:   ;
            endcase
        end
    end

    always_comb begin
        blink_d = blink_q;
        if (!in_set || state_chg || edit_ok || edit_dec)
            blink_d = 1'b0;
        else if (tick_2hz)
            blink_d = ~blink_q;
    end

    always_comb begin
        idle_d = idle_q;
        if (!in_set || activity || state_chg)
            idle_d = '0;
        else if (tick_1hz && (TIMEOUT_S != 0))
            idle_d = idle_q + IW'(1);
    end

    // Output logic.
    always_comb begin
        hh        = hh_q;
        mm        = mm_q;
        ss        = ss_q;
        blink_en  = blink_q;
        blink_sel = state_q;
        setting   = in_set;
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: driver pushes hand-computed expectations into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_inc_lvl = 1'b0;
    logic [7:0] hh, mm, ss;
    logic       blink_en, setting;
    logic [1:0] blink_sel;

    logic [27:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;

    logic [7:0]  rep_mm[5];
    logic        rep_be[5];

    // Clock/reset block
    always #5 clk = ~clk;

    time_set_ctrl #(.TIMEOUT_S(30), .REPEAT_DLY(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_inc_lvl(btn_inc_lvl), .hh(hh), .mm(mm), .ss(ss),
        .blink_en(blink_en), .blink_sel(blink_sel), .setting(setting)
    );

    function automatic logic [27:0] pk(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s, input logic be,
                                       input logic [1:0] bs, input logic st);
        return {h, m, s, be, bs, st};
    endfunction

    task automatic expect_out(input string nm, input logic [27:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Driver tasks: called at posedge+1, drive one cycle, return at next posedge+1.
    task automatic drive(input logic m, input logic i, input logic d,
                         input logic a, input logic b);
        btn_mode = m; btn_inc = i; btn_dec = d; tick_1hz = a; tick_2hz = b;
        @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
    endtask

    task automatic mode();  drive(1, 0, 0, 0, 0); endtask
    task automatic inc();   drive(0, 1, 0, 0, 0); endtask
    task automatic dec();   drive(0, 0, 1, 0, 0); endtask
    task automatic tick1(); drive(0, 0, 0, 1, 0); endtask
    task automatic tick2(); drive(0, 0, 0, 0, 1); endtask
    task automatic idle();  drive(0, 0, 0, 0, 0); endtask

    // Scoreboard monitor
    always @(negedge clk) begin : monitor
        logic [27:0] e;
        logic [27:0] act;
        string nm;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {hh, mm, ss, blink_en, blink_sel, setting};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %h:%h:%h blink_en=%b blink_sel=%b setting=%b, expected %h:%h:%h blink_en=%b blink_sel=%b setting=%b",
                         nm, act[27:20], act[19:12], act[11:4], act[3], act[2:1], act[0],
                         e[27:20], e[19:12], e[11:4], e[3], e[2:1], e[0]);
            end
        end
    end

    initial begin
`ifdef INC_REPEAT_EN
        rep_mm = '{8'h58, 8'h58, 8'h59, 8'h00, 8'h01};
        rep_be = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        rep_mm = '{8'h58, 8'h58, 8'h58, 8'h58, 8'h58};
        rep_be = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", pk(8'h00, 8'h00, 8'h00, 0, 2'b11, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        repeat (3) tick1();
        expect_out("run_3ticks", pk(8'h00, 8'h00, 8'h03, 0, 2'b11, 0));

        mode();
        expect_out("enter_set_hh", pk(8'h00, 8'h00, 8'h03, 0, 2'b00, 1));
        dec();
        expect_out("hh_dec_wrap", pk(8'h23, 8'h00, 8'h03, 0, 2'b00, 1));
        tick2();
        expect_out("blink_toggle", pk(8'h23, 8'h00, 8'h03, 1, 2'b00, 1));
        inc();
        expect_out("hh_inc_wrap_blink_clr", pk(8'h00, 8'h00, 8'h03, 0, 2'b00, 1));
        dec();
        mode();
        dec();
        expect_out("mm_dec_wrap", pk(8'h23, 8'h59, 8'h03, 0, 2'b01, 1));
        mode();
        repeat (4) dec();
        expect_out("ss_dec_wrap", pk(8'h23, 8'h59, 8'h59, 0, 2'b10, 1));
        mode();
        expect_out("back_to_run", pk(8'h23, 8'h59, 8'h59, 0, 2'b11, 0));
        tick1();
        expect_out("midnight_rollover", pk(8'h00, 8'h00, 8'h00, 0, 2'b11, 0));

        mode();
        repeat (9) inc();
        expect_out("hh_09", pk(8'h09, 8'h00, 8'h00, 0, 2'b00, 1));
        inc();
        expect_out("hh_bcd_carry", pk(8'h10, 8'h00, 8'h00, 0, 2'b00, 1));
        dec();
        expect_out("hh_bcd_borrow", pk(8'h09, 8'h00, 8'h00, 0, 2'b00, 1));

        mode();
        inc();
        drive(0, 1, 1, 0, 0);
        expect_out("inc_dec_same", pk(8'h09, 8'h01, 8'h00, 0, 2'b01, 1));
        tick1();
        expect_out("set_frozen", pk(8'h09, 8'h01, 8'h00, 0, 2'b01, 1));
        drive(1, 1, 0, 0, 0);
        expect_out("mode_wins", pk(8'h09, 8'h01, 8'h00, 0, 2'b10, 1));
        dec();
        inc();
        expect_out("ss_inc_wrap", pk(8'h09, 8'h01, 8'h00, 0, 2'b10, 1));

        repeat (29) tick1();
        expect_out("timeout_29", pk(8'h09, 8'h01, 8'h00, 0, 2'b10, 1));
        tick1();
        expect_out("timeout_30", pk(8'h09, 8'h01, 8'h00, 0, 2'b11, 0));
        tick1();
        expect_out("run_after_timeout", pk(8'h09, 8'h01, 8'h01, 0, 2'b11, 0));

        drive(1, 0, 0, 1, 0);
        expect_out("mode_drops_tick", pk(8'h09, 8'h01, 8'h01, 0, 2'b00, 1));

        mode();
        repeat (3) dec();
        expect_out("mm_set_58", pk(8'h09, 8'h58, 8'h01, 0, 2'b01, 1));
        btn_inc_lvl = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle();
            tick2();
            expect_out($sformatf("repeat_tick%0d", k + 1),
                       pk(8'h09, rep_mm[k], 8'h01, rep_be[k], 2'b01, 1));
        end
        btn_inc_lvl = 1'b0;
        mode();
        mode();
        expect_out("repeat_exit_run", pk(8'h09, rep_mm[4], 8'h01, 0, 2'b11, 0));

        mode();
        inc();
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("reset_mid_edit", pk(8'h00, 8'h00, 8'h00, 0, 2'b11, 0));

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
